// File: rtl/bcd_converter_seq.sv
// Sequential binary-to-BCD converter using shift-and-add-3 (double dabble).
// One iteration per clock. Supports optional two's-complement input, shown
// as sign plus magnitude. Saturates to all nines when the magnitude does not
// fit in DIGITS decimal digits.
module bcd_converter_seq #(
    parameter int WIDTH  = 8,
    parameter int DIGITS = 3,
    parameter int SIGNED = 0
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_start,
    input  logic [WIDTH-1:0]      i_binary,
    output logic                  o_busy,
    output logic                  o_done,
    output logic [4*DIGITS-1:0]   o_bcd,
    output logic                  o_sign,
    output logic                  o_overflow
);

    localparam int BW = 4 * DIGITS;
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_ITER = CW'(WIDTH - 1);

    typedef enum logic {
        IDLE,
        SHIFT
    } state_t;

    state_t          r_state;
    state_t          w_stateNext;

    logic [CW-1:0]   r_count;
    logic [CW-1:0]   w_countNext;
    logic [WIDTH-1:0] r_bin;
    logic [WIDTH-1:0] w_binNext;
    logic [BW-1:0]   r_digits;
    logic [BW-1:0]   w_digitsNext;
    logic            r_ovfSticky;
    logic            w_ovfStickyNext;
    logic            r_signLat;
    logic            w_signLatNext;

    logic [BW-1:0]   r_bcd;
    logic [BW-1:0]   w_bcdNext;
    logic            r_sign;
    logic            w_signNext;
    logic            r_overflow;
    logic            w_overflowNext;
    logic            r_done;
    logic            w_doneNext;

    logic            w_isNeg;
    logic [WIDTH-1:0] w_mag;
    logic [BW-1:0]   w_corr;
    logic [BW-1:0]   w_shiftDigits;
    logic [WIDTH-1:0] w_shiftBin;
    logic            w_ovfAcc;
    logic [BW-1:0]   w_nines;

    // Negating a negative input gives its magnitude; for the most negative
    // value the unsigned reading of the result is still the right magnitude.
    assign w_isNeg = (SIGNED != 0) && i_binary[WIDTH-1];
    assign w_mag   = w_isNeg ? (~i_binary + WIDTH'(1)) : i_binary;

    // Apply the add-3 correction to every digit that is 5 or more, all at once.
    always_comb begin
        w_corr = r_digits;
        for (int i = 0; i < DIGITS; i++) begin
            if (r_digits[4*i +: 4] >= 4'd5) begin
                w_corr[4*i +: 4] = r_digits[4*i +: 4] + 4'd3;
            end
        end
    end

    // The top bit of the corrected digits falls off during the shift. If it is
    // ever set, the value no longer fits.
    assign w_shiftDigits = {w_corr[BW-2:0], r_bin[WIDTH-1]};
    assign w_shiftBin    = r_bin << 1;
    assign w_ovfAcc      = r_ovfSticky | w_corr[BW-1];
    assign w_nines       = {DIGITS{4'h9}};

    // Next-state and datapath updates for the IDLE/SHIFT controller.
    always_comb begin
        w_stateNext     = r_state;
        w_countNext     = r_count;
        w_binNext       = r_bin;
        w_digitsNext    = r_digits;
        w_ovfStickyNext = r_ovfSticky;
        w_signLatNext   = r_signLat;
        w_bcdNext       = r_bcd;
        w_signNext      = r_sign;
        w_overflowNext  = r_overflow;
        w_doneNext      = 1'b0;

        case (r_state)
            IDLE: begin
                if (i_start) begin
                    w_stateNext     = SHIFT;
                    w_countNext     = '0;
                    w_binNext       = w_mag;
                    w_digitsNext    = '0;
                    w_ovfStickyNext = 1'b0;
                    w_signLatNext   = w_isNeg;
                end
            end
            SHIFT: begin
                w_binNext       = w_shiftBin;
                w_digitsNext    = w_shiftDigits;
                w_ovfStickyNext = w_ovfAcc;
                w_countNext     = r_count + CW'(1);
                if (r_count == LAST_ITER) begin
                    w_bcdNext      = w_ovfAcc ? w_nines : w_shiftDigits;
                    w_signNext     = r_signLat;
                    w_overflowNext = w_ovfAcc;
                    w_doneNext     = 1'b1;
                    w_countNext    = '0;
                    w_stateNext    = IDLE;
                end
            end
            default: begin
                w_stateNext = IDLE;
            end
        endcase
    end

    // State and datapath registers. Reset aborts any conversion in progress.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state     <= IDLE;
            r_count     <= '0;
            r_bin       <= '0;
            r_digits    <= '0;
            r_ovfSticky <= 1'b0;
            r_signLat   <= 1'b0;
            r_bcd       <= '0;
            r_sign      <= 1'b0;
            r_overflow  <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_state     <= w_stateNext;
            r_count     <= w_countNext;
            r_bin       <= w_binNext;
            r_digits    <= w_digitsNext;
            r_ovfSticky <= w_ovfStickyNext;
            r_signLat   <= w_signLatNext;
            r_bcd       <= w_bcdNext;
            r_sign      <= w_signNext;
            r_overflow  <= w_overflowNext;
            r_done      <= w_doneNext;
        end
    end

    assign o_busy     = (r_state != IDLE);
    assign o_done     = r_done;
    assign o_bcd      = r_bcd;
    assign o_sign     = r_sign;
    assign o_overflow = r_overflow;

endmodule

// File: tb/tb_bcd_converter_seq.sv
// Testbench for bcd_converter_seq. Four instances cover the default, wide,
// signed and two-digit configurations. Expected results are queued when a
// conversion starts and are compared when done fires.
module tb_bcd_converter_seq;

    typedef struct {
        logic [19:0] bcd;
        logic        sign;
        logic        ovf;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;

    logic        st0, st1, st2, st3;
    logic [7:0]  bin0, bin2, bin3;
    logic [15:0] bin1;

    logic        d0Busy, d0Done, d0Sign, d0Ovf;
    logic [11:0] d0Bcd;
    logic        d1Busy, d1Done, d1Sign, d1Ovf;
    logic [19:0] d1Bcd;
    logic        d2Busy, d2Done, d2Sign, d2Ovf;
    logic [11:0] d2Bcd;
    logic        d3Busy, d3Done, d3Sign, d3Ovf;
    logic [7:0]  d3Bcd;

    int          nChecks = 0;
    int          nPass   = 0;
    exp_t        expQ[$];
    logic [11:0] lastBcd0 = '0;

    bcd_converter_seq #(.WIDTH(8), .DIGITS(3), .SIGNED(0)) dut0 (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(st0), .i_binary(bin0),
        .o_busy(d0Busy), .o_done(d0Done), .o_bcd(d0Bcd), .o_sign(d0Sign), .o_overflow(d0Ovf));

    bcd_converter_seq #(.WIDTH(16), .DIGITS(5), .SIGNED(0)) dut1 (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(st1), .i_binary(bin1),
        .o_busy(d1Busy), .o_done(d1Done), .o_bcd(d1Bcd), .o_sign(d1Sign), .o_overflow(d1Ovf));

    bcd_converter_seq #(.WIDTH(8), .DIGITS(3), .SIGNED(1)) dut2 (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(st2), .i_binary(bin2),
        .o_busy(d2Busy), .o_done(d2Done), .o_bcd(d2Bcd), .o_sign(d2Sign), .o_overflow(d2Ovf));

    bcd_converter_seq #(.WIDTH(8), .DIGITS(2), .SIGNED(0)) dut3 (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(st3), .i_binary(bin3),
        .o_busy(d3Busy), .o_done(d3Done), .o_bcd(d3Bcd), .o_sign(d3Sign), .o_overflow(d3Ovf));

    always #5 clk = ~clk;

    function automatic logic [19:0] toBcd(input int v);
        logic [19:0] r;
        int t;
        r = '0;
        t = v;
        for (int i = 0; i < 5; i++) begin
            r[4*i +: 4] = 4'(t % 10);
            t = t / 10;
        end
        return r;
    endfunction

    function automatic logic readDone(input int which);
        case (which)
            0: return d0Done;
            1: return d1Done;
            2: return d2Done;
            3: return d3Done;
            default: return 1'b0;
        endcase
    endfunction

    task automatic setInputs(input int which, input logic s, input logic [15:0] v);
        case (which)
            0: begin st0 = s; bin0 = v[7:0]; end
            1: begin st1 = s; bin1 = v;      end
            2: begin st2 = s; bin2 = v[7:0]; end
            default: begin st3 = s; bin3 = v[7:0]; end
        endcase
    endtask

    // Raise start for one edge; on return we are just past the accepting edge.
    task automatic pulseStart(input int which, input logic [15:0] v);
        setInputs(which, 1'b1, v);
        @(posedge clk);
        #1;
        setInputs(which, 1'b0, v);
    endtask

    // Count edges until done is seen; -1 when the budget runs out.
    task automatic waitDone(input int which, input int budget, output int cycles);
        bit found;
        found  = 1'b0;
        cycles = -1;
        for (int c = 1; c <= budget && !found; c++) begin
            @(posedge clk);
            #1;
            if (readDone(which)) begin
                found  = 1'b1;
                cycles = c;
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        for (int w = 0; w < 4; w++) setInputs(w, 1'b0, 16'h0);
        repeat (2) @(posedge clk);
        #1;
        nChecks++;
        if ({d0Busy, d0Done, d0Sign, d0Ovf} !== 4'b0000)
            $display("[TB] FAIL reset_flags: got %b expected 0000", {d0Busy, d0Done, d0Sign, d0Ovf});
        else nPass++;
        nChecks++;
        if (d0Bcd !== 12'h000) $display("[TB] FAIL reset_bcd0: got %h expected 000", d0Bcd);
        else nPass++;
        nChecks++;
        if (d1Bcd !== 20'h00000 || d1Busy !== 1'b0)
            $display("[TB] FAIL reset_dut1: got bcd %h busy %b expected 00000/0", d1Bcd, d1Busy);
        else nPass++;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        nChecks++;
        if (d0Busy !== 1'b0 || d0Done !== 1'b0)
            $display("[TB] FAIL reset_release: got busy %b done %b expected 0/0", d0Busy, d0Done);
        else nPass++;
    endtask

    task automatic test_unsigned();
        int          vals[6] = '{255, 0, 5, 10, 128, 199};
        logic [19:0] exps[6] = '{20'h255, 20'h000, 20'h005, 20'h010, 20'h128, 20'h199};
        for (int i = 0; i < 6; i++) begin
            exp_t e;
            int   c;
            expQ.push_back('{bcd: exps[i], sign: 1'b0, ovf: 1'b0});
            pulseStart(0, 16'(vals[i]));
            nChecks++;
            if (d0Busy !== 1'b1) $display("[TB] FAIL unsigned_busy %0d: got %b expected 1", vals[i], d0Busy);
            else nPass++;
            nChecks++;
            if (d0Bcd !== lastBcd0) $display("[TB] FAIL unsigned_hold %0d: got %h expected %h", vals[i], d0Bcd, lastBcd0);
            else nPass++;
            waitDone(0, 20, c);
            nChecks++;
            if (c != 8) $display("[TB] FAIL unsigned_latency %0d: got %0d expected 8", vals[i], c);
            else nPass++;
            e = expQ.pop_front();
            nChecks++;
            if ({8'h00, d0Bcd} !== e.bcd || d0Sign !== e.sign || d0Ovf !== e.ovf)
                $display("[TB] FAIL unsigned_result %0d: got %h/%b/%b expected %h/%b/%b",
                         vals[i], d0Bcd, d0Sign, d0Ovf, e.bcd, e.sign, e.ovf);
            else nPass++;
            @(posedge clk);
            #1;
            nChecks++;
            if (d0Done !== 1'b0 || d0Busy !== 1'b0)
                $display("[TB] FAIL unsigned_done_pulse %0d: got done %b busy %b expected 0/0", vals[i], d0Done, d0Busy);
            else nPass++;
            lastBcd0 = e.bcd[11:0];
        end
    endtask

    task automatic test_wide();
        int          vals[7];
        logic [19:0] exps[7];
        vals[0] = 65535; exps[0] = 20'h65535;
        vals[1] = 40960; exps[1] = 20'h40960;
        vals[2] = 0;     exps[2] = 20'h00000;
        vals[3] = 12345; exps[3] = 20'h12345;
        for (int i = 4; i < 7; i++) begin
            vals[i] = int'($urandom_range(65535, 0));
            exps[i] = toBcd(vals[i]);
        end
        for (int i = 0; i < 7; i++) begin
            exp_t e;
            int   c;
            expQ.push_back('{bcd: exps[i], sign: 1'b0, ovf: 1'b0});
            pulseStart(1, 16'(vals[i]));
            waitDone(1, 30, c);
            nChecks++;
            if (c != 16) $display("[TB] FAIL wide_latency %0d: got %0d expected 16", vals[i], c);
            else nPass++;
            e = expQ.pop_front();
            nChecks++;
            if (d1Bcd !== e.bcd || d1Ovf !== e.ovf || d1Sign !== e.sign)
                $display("[TB] FAIL wide_result %0d: got %h/%b expected %h/%b", vals[i], d1Bcd, d1Ovf, e.bcd, e.ovf);
            else nPass++;
        end
    endtask

    task automatic test_signed();
        logic [7:0]  vals[5]  = '{8'h80, 8'hFF, 8'h7F, 8'h00, 8'h81};
        logic [19:0] exps[5]  = '{20'h128, 20'h001, 20'h127, 20'h000, 20'h127};
        logic        signs[5] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
        for (int i = 0; i < 5; i++) begin
            exp_t e;
            int   c;
            expQ.push_back('{bcd: exps[i], sign: signs[i], ovf: 1'b0});
            pulseStart(2, {8'h00, vals[i]});
            waitDone(2, 20, c);
            e = expQ.pop_front();
            nChecks++;
            if (c != 8 || {8'h00, d2Bcd} !== e.bcd || d2Sign !== e.sign || d2Ovf !== e.ovf)
                $display("[TB] FAIL signed_result %h: got lat %0d %h/%b/%b expected lat 8 %h/%b/%b",
                         vals[i], c, d2Bcd, d2Sign, d2Ovf, e.bcd, e.sign, e.ovf);
            else nPass++;
        end
    endtask

    task automatic test_overflow();
        int          vals[6] = '{100, 42, 99, 255, 0, 0};
        logic [19:0] exps[6] = '{20'h99, 20'h42, 20'h99, 20'h99, 20'h00, 20'h00};
        logic        ovfs[6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        vals[5] = int'($urandom_range(255, 0));
        exps[5] = (vals[5] > 99) ? 20'h99 : toBcd(vals[5]);
        ovfs[5] = (vals[5] > 99);
        for (int i = 0; i < 6; i++) begin
            exp_t e;
            int   c;
            expQ.push_back('{bcd: exps[i], sign: 1'b0, ovf: ovfs[i]});
            pulseStart(3, 16'(vals[i]));
            waitDone(3, 20, c);
            e = expQ.pop_front();
            nChecks++;
            if (c != 8 || {12'h000, d3Bcd} !== e.bcd || d3Ovf !== e.ovf || d3Sign !== e.sign)
                $display("[TB] FAIL overflow_result %0d: got lat %0d %h/ovf %b expected lat 8 %h/ovf %b",
                         vals[i], c, d3Bcd, d3Ovf, e.bcd, e.ovf);
            else nPass++;
        end
    endtask

    task automatic test_back_to_back();
        exp_t e;
        int   c;
        int   extra;
        expQ.push_back('{bcd: 20'h037, sign: 1'b0, ovf: 1'b0});
        expQ.push_back('{bcd: 20'h099, sign: 1'b0, ovf: 1'b0});
        setInputs(0, 1'b1, 16'd37);
        @(posedge clk);
        #1;
        bin0 = 8'd99;
        waitDone(0, 20, c);
        nChecks++;
        if (c != 8) $display("[TB] FAIL b2b_first_latency: got %0d expected 8", c);
        else nPass++;
        e = expQ.pop_front();
        nChecks++;
        if ({8'h00, d0Bcd} !== e.bcd) $display("[TB] FAIL b2b_first_bcd: got %h expected %h", d0Bcd, e.bcd);
        else nPass++;
        waitDone(0, 20, c);
        setInputs(0, 1'b0, 16'd99);
        nChecks++;
        if (c != 9) $display("[TB] FAIL b2b_spacing: got %0d expected 9", c);
        else nPass++;
        e = expQ.pop_front();
        nChecks++;
        if ({8'h00, d0Bcd} !== e.bcd) $display("[TB] FAIL b2b_second_bcd: got %h expected %h", d0Bcd, e.bcd);
        else nPass++;
        extra = 0;
        for (int k = 0; k < 12; k++) begin
            @(posedge clk);
            #1;
            if (d0Done === 1'b1 || d0Busy === 1'b1) extra++;
        end
        nChecks++;
        if (extra != 0) $display("[TB] FAIL b2b_stop: got %0d active cycles expected 0", extra);
        else nPass++;
        lastBcd0 = e.bcd[11:0];
    endtask

    task automatic test_ignore_start();
        exp_t e;
        int   c;
        int   extra;
        expQ.push_back('{bcd: 20'h123, sign: 1'b0, ovf: 1'b0});
        pulseStart(0, 16'd123);
        repeat (3) @(posedge clk);
        #1;
        setInputs(0, 1'b1, 16'd5);
        @(posedge clk);
        #1;
        setInputs(0, 1'b0, 16'd5);
        waitDone(0, 20, c);
        nChecks++;
        if (c != 4) $display("[TB] FAIL ignore_latency: got %0d expected 4", c);
        else nPass++;
        e = expQ.pop_front();
        nChecks++;
        if ({8'h00, d0Bcd} !== e.bcd) $display("[TB] FAIL ignore_bcd: got %h expected %h", d0Bcd, e.bcd);
        else nPass++;
        extra = 0;
        for (int k = 0; k < 12; k++) begin
            @(posedge clk);
            #1;
            if (d0Done === 1'b1 || d0Busy === 1'b1) extra++;
        end
        nChecks++;
        if (extra != 0) $display("[TB] FAIL ignore_no_queue: got %0d active cycles expected 0", extra);
        else nPass++;
        lastBcd0 = e.bcd[11:0];
    endtask

    task automatic test_reset_abort();
        exp_t e;
        int   c;
        int   dones;
        pulseStart(0, 16'd200);
        repeat (3) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        nChecks++;
        if (d0Busy !== 1'b0 || d0Bcd !== 12'h000 || d0Done !== 1'b0)
            $display("[TB] FAIL abort_immediate: got busy %b bcd %h done %b expected 0/000/0", d0Busy, d0Bcd, d0Done);
        else nPass++;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        dones = 0;
        for (int k = 0; k < 12; k++) begin
            @(posedge clk);
            #1;
            if (d0Done === 1'b1) dones++;
        end
        nChecks++;
        if (dones != 0 || d0Bcd !== 12'h000)
            $display("[TB] FAIL abort_no_done: got %0d dones bcd %h expected 0/000", dones, d0Bcd);
        else nPass++;
        expQ.push_back('{bcd: 20'h200, sign: 1'b0, ovf: 1'b0});
        pulseStart(0, 16'd200);
        waitDone(0, 20, c);
        e = expQ.pop_front();
        nChecks++;
        if (c != 8 || {8'h00, d0Bcd} !== e.bcd)
            $display("[TB] FAIL abort_restart: got lat %0d bcd %h expected lat 8 %h", c, d0Bcd, e.bcd);
        else nPass++;
    endtask

    initial begin
        test_reset();
        test_unsigned();
        test_wide();
        test_signed();
        test_overflow();
        test_back_to_back();
        test_ignore_start();
        test_reset_abort();
        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] simulation time limit reached");
    end

endmodule
